// File: rtl/wide_ram_reader_pkg.sv
// Shared types and constants for the wide RAM reader: FSM encoding and the
// lane geometry used to serialise one wide RAM word into output beats.
package wide_ram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Beats per wide word; DATA_WIDTH must equal LANES * OUT_WIDTH.
    localparam int LANES      = 8;
    localparam int LANE_IDX_W = $clog2(LANES);

endpackage

// File: rtl/wide_ram_reader_word_fifo2.sv
// Two-entry word FIFO holding wide RAM words between capture and
// serialisation. Push and pop in the same cycle keep occupancy unchanged.
module word_fifo2 #(
    parameter int WIDTH = 128
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_r [2];
    logic             wrPtr_r;
    logic             rdPtr_r;
    logic [1:0]       count_r;
    logic             pushEn_s;
    logic             popEn_s;

    // Qualify push/pop against occupancy; a push into a full FIFO is only
    // allowed when the head leaves in the same cycle.
    always_comb begin
        popEn_s  = pop && (count_r != 2'd0);
        pushEn_s = push && ((count_r != 2'd2) || popEn_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wrPtr_r  <= 1'b0;
            rdPtr_r  <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (pushEn_s) begin
                mem_r[wrPtr_r] <= pushData;
                wrPtr_r        <= ~wrPtr_r;
            end
            if (popEn_s) begin
                rdPtr_r <= ~rdPtr_r;
            end
            case ({pushEn_s, popEn_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rdPtr_r];
    assign full  = (count_r == 2'd2);
    assign empty = (count_r == 2'd0);
    assign count = count_r;

endmodule

// File: rtl/wide_ram_reader.sv
// Read-side master for the wide RAM port: fetches a run of wide words and
// streams them out lane 0 first as narrow beats over valid/ready.
module wide_ram_reader
    import wide_ram_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int OUT_WIDTH  = 16,
    parameter int DATA_WIDTH = LANES * OUT_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_start,
    input  logic [ADDR_WIDTH-1:0] io_startAddr,
    input  logic [ADDR_WIDTH-1:0] io_count,
    output logic                  io_busy,
    output logic                  io_done,
    output logic                  io_ram_rd,
    output logic [ADDR_WIDTH-1:0] io_ram_addr,
    input  logic [DATA_WIDTH-1:0] io_ram_dout,
    output logic                  io_out_valid,
    input  logic                  io_out_ready,
    output logic [OUT_WIDTH-1:0]  io_out_bits
);

    localparam logic [ADDR_WIDTH-1:0] addrOne  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LANE_IDX_W-1:0] lastLane = LANE_IDX_W'(LANES - 1);

    state_t                  state_r;
    state_t                  nextState_s;
    logic                    busy_r;
    logic                    done_r;
    logic                    ramRd_r;
    logic                    capture_r;
    logic [ADDR_WIDTH-1:0]   ramAddr_r;
    logic [ADDR_WIDTH-1:0]   nextAddr_r;
    logic [ADDR_WIDTH-1:0]   readsLeft_r;
    logic [ADDR_WIDTH-1:0]   wordsLeft_r;
    logic [LANE_IDX_W-1:0]   lane_r;
    logic                    issue_s;
    logic                    startAccept_s;
    logic                    beat_s;
    logic                    pop_s;
    logic [2:0]              credit_s;
    logic [DATA_WIDTH-1:0]   fifoHead_s;
    logic                    fifoFull_s;
    logic                    fifoEmpty_s;
    logic [1:0]              fifoCount_s;
    logic [OUT_WIDTH-1:0]    lanes_s [LANES];

    // Words returned by the RAM are pushed the cycle after the read strobe.
    word_fifo2 #(.WIDTH(DATA_WIDTH)) uFifo (
        .clock    (clock),
        .reset    (reset),
        .push     (capture_r),
        .pushData (io_ram_dout),
        .pop      (pop_s),
        .head     (fifoHead_s),
        .full     (fifoFull_s),
        .empty    (fifoEmpty_s),
        .count    (fifoCount_s)
    );

    for (genvar g = 0; g < LANES; g++) begin : gLane
        assign lanes_s[g] = fifoHead_s[g*OUT_WIDTH +: OUT_WIDTH];
    end

    // Next state, read issue and beat handshake decode. Reads are only
    // issued while buffered plus in-flight words stay below two, counting
    // both the strobe in progress and the word being captured this cycle.
    always_comb begin
        nextState_s   = state_r;
        issue_s       = 1'b0;
        startAccept_s = 1'b0;
        beat_s        = (!fifoEmpty_s) && io_out_ready;
        pop_s         = beat_s && (lane_r == lastLane);
        credit_s      = {1'b0, fifoCount_s} + {2'b00, ramRd_r} + {2'b00, capture_r};
        case (state_r)
            IDLE, DONE: begin
                if (io_start) begin
                    startAccept_s = 1'b1;
                    if (io_count != '0) begin
                        issue_s     = 1'b1;
                        nextState_s = FETCH;
                    end else begin
                        nextState_s = DONE;
                    end
                end else begin
                    nextState_s = IDLE;
                end
            end
            FETCH: begin
                if (readsLeft_r == '0) begin
                    nextState_s = DRAIN;
                end else if ((credit_s < 3'd2) && !fifoFull_s) begin
                    issue_s = 1'b1;
                end else begin
                    issue_s = 1'b0;
                end
            end
            DRAIN: begin
                if (pop_s && (wordsLeft_r == addrOne)) begin
                    nextState_s = DONE;
                end else begin
                    nextState_s = DRAIN;
                end
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // State register plus registered busy/done status decoded from it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= nextState_s;
            busy_r  <= (nextState_s == FETCH) || (nextState_s == DRAIN);
            done_r  <= (nextState_s == DONE);
        end
    end

    // Read strobe/address, remaining-work counters and the lane counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            ramRd_r     <= 1'b0;
            capture_r   <= 1'b0;
            ramAddr_r   <= '0;
            nextAddr_r  <= '0;
            readsLeft_r <= '0;
            wordsLeft_r <= '0;
            lane_r      <= '0;
        end else begin
            ramRd_r   <= issue_s;
            capture_r <= ramRd_r;
            if (issue_s) begin
                if (startAccept_s) begin
                    ramAddr_r   <= io_startAddr;
                    nextAddr_r  <= io_startAddr + addrOne;
                    readsLeft_r <= io_count - addrOne;
                end else begin
                    ramAddr_r   <= nextAddr_r;
                    nextAddr_r  <= nextAddr_r + addrOne;
                    readsLeft_r <= readsLeft_r - addrOne;
                end
            end
            if (startAccept_s) begin
                wordsLeft_r <= io_count;
            end else if (pop_s) begin
                wordsLeft_r <= wordsLeft_r - addrOne;
            end
            if (beat_s) begin
                lane_r <= (lane_r == lastLane) ? '0 : lane_r + 1'b1;
            end
        end
    end

    assign io_busy      = busy_r;
    assign io_done      = done_r;
    assign io_ram_rd    = ramRd_r;
    assign io_ram_addr  = ramAddr_r;
    assign io_out_valid = !fifoEmpty_s;
    assign io_out_bits  = lanes_s[lane_r];

endmodule

// File: tb/tb_wide_ram_reader.sv
// Self-checking bench for wide_ram_reader: a behavioural RAM plus a
// reference model that expands each command into its address list and
// expected beat stream; per-scenario tasks compare observed behaviour.
module tb_wide_ram_reader;

    localparam int MODE_READY  = 0;
    localparam int MODE_TOGGLE = 1;
    localparam int MODE_RAND   = 2;

    logic         clock;
    logic         reset;
    logic         io_start;
    logic [11:0]  io_startAddr;
    logic [11:0]  io_count;
    logic         io_busy;
    logic         io_done;
    logic         io_ram_rd;
    logic [11:0]  io_ram_addr;
    logic [127:0] io_ram_dout;
    logic         io_out_valid;
    logic         io_out_ready;
    logic [15:0]  io_out_bits;

    logic [127:0] ramMem [0:4095];

    int checks;
    int errors;

    // Observation record for the current scenario
    int          cyc;
    int          rdCount;
    logic [11:0] rdAddrs[$];
    int          rdCycles[$];
    logic [15:0] beats[$];
    int          beatCycles[$];
    int          doneCycles[$];
    int          busyCount;
    int          holdViol;
    int          outstanding;
    int          maxOut;
    int          laneSeen;
    logic        prevValid;
    logic        prevReady;
    logic [15:0] prevBits;

    // Reference model expectations
    logic [11:0] expAddrs[$];
    logic [15:0] expBeats[$];

    wide_ram_reader dut (
        .clock        (clock),
        .reset        (reset),
        .io_start     (io_start),
        .io_startAddr (io_startAddr),
        .io_count     (io_count),
        .io_busy      (io_busy),
        .io_done      (io_done),
        .io_ram_rd    (io_ram_rd),
        .io_ram_addr  (io_ram_addr),
        .io_ram_dout  (io_ram_dout),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_bits  (io_out_bits)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural RAM: data returned one cycle after the read strobe
    always @(posedge clock) begin
        if (io_ram_rd) io_ram_dout <= ramMem[io_ram_addr];
    end

    task automatic clear_obs();
        cyc = 0; rdCount = 0; busyCount = 0; holdViol = 0;
        outstanding = 0; maxOut = 0; laneSeen = 0;
        prevValid = 1'b0; prevReady = 1'b0; prevBits = 16'h0000;
        rdAddrs.delete(); rdCycles.delete(); beats.delete();
        beatCycles.delete(); doneCycles.delete();
        expAddrs.delete(); expBeats.delete();
    endtask

    // Reference model: a command reads cnt words from consecutive addresses
    // (mod 4096) and each word leaves as 8 beats, least significant first.
    task automatic model_cmd(input logic [11:0] addr, input int cnt);
        logic [11:0]  a;
        logic [127:0] word;
        for (int w = 0; w < cnt; w++) begin
            a = addr + 12'(w);
            expAddrs.push_back(a);
            word = ramMem[a];
            for (int l = 0; l < 8; l++) expBeats.push_back(word[l*16 +: 16]);
        end
    endtask

    function automatic int first_diff_beats();
        int n;
        n = (beats.size() < expBeats.size()) ? beats.size() : expBeats.size();
        for (int i = 0; i < n; i++) if (beats[i] !== expBeats[i]) return i;
        if (beats.size() != expBeats.size()) return n;
        return -1;
    endfunction

    function automatic int first_diff_addrs();
        int n;
        n = (rdAddrs.size() < expAddrs.size()) ? rdAddrs.size() : expAddrs.size();
        for (int i = 0; i < n; i++) if (rdAddrs[i] !== expAddrs[i]) return i;
        if (rdAddrs.size() != expAddrs.size()) return n;
        return -1;
    endfunction

    // One clock cycle: drive ready, sample at negedge, record what happened.
    task automatic observe_cycle(input int mode);
        case (mode)
            MODE_READY:  io_out_ready = 1'b1;
            MODE_TOGGLE: io_out_ready = ((cyc % 2) == 0);
            default:     io_out_ready = 1'($urandom_range(0, 1));
        endcase
        @(negedge clock);
        if (prevValid && !prevReady && ((io_out_valid !== 1'b1) || (io_out_bits !== prevBits)))
            holdViol++;
        if (io_ram_rd === 1'b1) begin
            rdCount++;
            rdAddrs.push_back(io_ram_addr);
            rdCycles.push_back(cyc);
            outstanding++;
        end
        if (outstanding > maxOut) maxOut = outstanding;
        if (io_out_valid === 1'b1 && io_out_ready) begin
            beats.push_back(io_out_bits);
            beatCycles.push_back(cyc);
            laneSeen++;
            if (laneSeen == 8) begin
                laneSeen = 0;
                outstanding--;
            end
        end
        if (io_done === 1'b1) doneCycles.push_back(cyc);
        if (io_busy === 1'b1) busyCount++;
        prevValid = io_out_valid;
        prevReady = io_out_ready;
        prevBits  = io_out_bits;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic issue_start(input logic [11:0] addr, input int cnt, input int mode);
        io_start     = 1'b1;
        io_startAddr = addr;
        io_count     = 12'(cnt);
        observe_cycle(mode);
        io_start     = 1'b0;
        io_startAddr = 12'($urandom);
        io_count     = 12'($urandom);
    endtask

    task automatic run_until_done(input int want, input int bound, input int mode);
        for (int i = 0; i < bound && doneCycles.size() < want; i++) observe_cycle(mode);
        for (int i = 0; i < 3; i++) observe_cycle(mode);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++; if (io_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", io_busy); end
        checks++; if (io_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", io_done); end
        checks++; if (io_ram_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b expected 0", io_ram_rd); end
        checks++; if (io_ram_addr !== 12'h000) begin errors++; $display("FAIL reset_addr: got %h expected 000", io_ram_addr); end
        checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", io_out_valid); end
        checks++; if (io_out_bits !== 16'h0000) begin errors++; $display("FAIL reset_bits: got %h expected 0000", io_out_bits); end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_single_word();
        int bad;
        clear_obs();
        for (int l = 0; l < 8; l++) ramMem[12'h010][l*16 +: 16] = 16'(l);
        model_cmd(12'h010, 1);
        issue_start(12'h010, 1, MODE_READY);
        run_until_done(1, 40, MODE_READY);
        bad = first_diff_beats();
        checks++; if (bad >= 0) begin errors++; $display("FAIL single_beats: first bad index %0d of %0d beats, expected %0d beats 0..7", bad, beats.size(), expBeats.size()); end
        bad = -1;
        for (int i = 0; i < beatCycles.size(); i++) if (beatCycles[i] != 3 + i && bad < 0) bad = i;
        checks++; if (bad >= 0) begin errors++; $display("FAIL single_timing: beat %0d at cycle %0d expected %0d", bad, beatCycles[bad], 3 + bad); end
        checks++; if (doneCycles.size() != 1 || doneCycles[0] != 11) begin errors++; $display("FAIL single_done: got %0d pulses first at %0d expected 1 at 11", doneCycles.size(), (doneCycles.size() > 0) ? doneCycles[0] : -1); end
        checks++; if (rdCount != 1 || rdCycles[0] != 1 || rdAddrs[0] !== 12'h010) begin errors++; $display("FAIL single_read: got %0d reads expected 1 at cycle 1 addr 010", rdCount); end
    endtask

    task automatic test_back_pressure();
        logic [11:0] a;
        int bad;
        clear_obs();
        a = 12'($urandom);
        model_cmd(a, 3);
        issue_start(a, 3, MODE_TOGGLE);
        run_until_done(1, 200, MODE_TOGGLE);
        bad = first_diff_beats();
        checks++; if (bad >= 0) begin errors++; $display("FAIL bp_beats: first bad index %0d, got %0d beats expected %0d", bad, beats.size(), expBeats.size()); end
        checks++; if (holdViol != 0) begin errors++; $display("FAIL bp_hold: got %0d hold violations expected 0", holdViol); end
        checks++; if (maxOut > 2) begin errors++; $display("FAIL bp_outstanding: got %0d words outstanding expected at most 2", maxOut); end
        checks++; if (rdCount != 3) begin errors++; $display("FAIL bp_reads: got %0d reads expected 3", rdCount); end
        checks++; if (doneCycles.size() != 1) begin errors++; $display("FAIL bp_done: got %0d pulses expected 1", doneCycles.size()); end
    endtask

    task automatic test_wrap();
        int bad;
        clear_obs();
        model_cmd(12'hFFE, 4);
        issue_start(12'hFFE, 4, MODE_RAND);
        run_until_done(1, 400, MODE_RAND);
        bad = first_diff_addrs();
        checks++; if (bad >= 0) begin errors++; $display("FAIL wrap_addrs: first bad index %0d got %0d reads expected FFE FFF 000 001", bad, rdAddrs.size()); end
        bad = first_diff_beats();
        checks++; if (bad >= 0) begin errors++; $display("FAIL wrap_beats: first bad index %0d got %0d beats expected %0d", bad, beats.size(), expBeats.size()); end
        checks++; if (holdViol != 0 || maxOut > 2) begin errors++; $display("FAIL wrap_flow: got hold %0d outstanding %0d expected 0 and <=2", holdViol, maxOut); end
    endtask

    task automatic test_zero_count();
        clear_obs();
        issue_start(12'($urandom), 0, MODE_READY);
        for (int i = 0; i < 5; i++) observe_cycle(MODE_READY);
        checks++; if (doneCycles.size() != 1 || doneCycles[0] != 1) begin errors++; $display("FAIL zero_done: got %0d pulses first at %0d expected 1 at 1", doneCycles.size(), (doneCycles.size() > 0) ? doneCycles[0] : -1); end
        checks++; if (busyCount != 0) begin errors++; $display("FAIL zero_busy: got %0d busy cycles expected 0", busyCount); end
        checks++; if (rdCount != 0) begin errors++; $display("FAIL zero_reads: got %0d reads expected 0", rdCount); end
    endtask

    task automatic test_throughput();
        logic [11:0] a;
        int cnt;
        int bad;
        clear_obs();
        a   = 12'($urandom);
        cnt = $urandom_range(2, 4);
        model_cmd(a, cnt);
        issue_start(a, cnt, MODE_READY);
        run_until_done(1, 100, MODE_READY);
        bad = first_diff_beats();
        checks++; if (bad >= 0) begin errors++; $display("FAIL tput_beats: first bad index %0d got %0d beats expected %0d", bad, beats.size(), expBeats.size()); end
        bad = -1;
        for (int i = 0; i < beatCycles.size(); i++) if (beatCycles[i] != 3 + i && bad < 0) bad = i;
        checks++; if (bad >= 0) begin errors++; $display("FAIL tput_bubble: beat %0d at cycle %0d expected %0d", bad, beatCycles[bad], 3 + bad); end
        checks++; if (doneCycles.size() != 1 || doneCycles[0] != 3 + 8 * cnt) begin errors++; $display("FAIL tput_done: got %0d pulses first at %0d expected 1 at %0d", doneCycles.size(), (doneCycles.size() > 0) ? doneCycles[0] : -1, 3 + 8 * cnt); end
    endtask

    task automatic test_start_while_busy();
        logic [11:0] a;
        int bad;
        clear_obs();
        a = 12'($urandom);
        model_cmd(a, 2);
        issue_start(a, 2, MODE_READY);
        for (int i = 0; i < 3; i++) observe_cycle(MODE_READY);
        issue_start(a + 12'h123, 5, MODE_READY);
        run_until_done(1, 100, MODE_READY);
        for (int i = 0; i < 20; i++) observe_cycle(MODE_READY);
        bad = first_diff_beats();
        checks++; if (bad >= 0) begin errors++; $display("FAIL busy_beats: first bad index %0d got %0d beats expected %0d", bad, beats.size(), expBeats.size()); end
        bad = first_diff_addrs();
        checks++; if (bad >= 0) begin errors++; $display("FAIL busy_reads: first bad index %0d got %0d reads expected %0d", bad, rdAddrs.size(), expAddrs.size()); end
        checks++; if (doneCycles.size() != 1) begin errors++; $display("FAIL busy_done: got %0d pulses expected 1", doneCycles.size()); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] a1;
        logic [11:0] a2;
        int bad;
        clear_obs();
        a1 = 12'($urandom);
        a2 = 12'($urandom);
        model_cmd(a1, 1);
        model_cmd(a2, 1);
        issue_start(a1, 1, MODE_READY);
        for (int i = 0; i < 10; i++) observe_cycle(MODE_READY);
        issue_start(a2, 1, MODE_READY);
        run_until_done(2, 40, MODE_READY);
        bad = first_diff_beats();
        checks++; if (bad >= 0) begin errors++; $display("FAIL b2b_beats: first bad index %0d got %0d beats expected %0d", bad, beats.size(), expBeats.size()); end
        checks++; if (doneCycles.size() != 2 || doneCycles[0] != 11 || doneCycles[1] != 22) begin errors++; $display("FAIL b2b_done: got %0d pulses expected 2 at cycles 11 and 22", doneCycles.size()); end
    endtask

    task automatic test_reset_mid_stream();
        logic [11:0] a;
        int bad;
        clear_obs();
        a = 12'($urandom);
        model_cmd(a, 2);
        issue_start(a, 2, MODE_READY);
        for (int i = 0; i < 50 && beats.size() < 5; i++) observe_cycle(MODE_READY);
        bad = -1;
        for (int i = 0; i < beats.size(); i++) if (beats[i] !== expBeats[i] && bad < 0) bad = i;
        checks++; if (beats.size() != 5 || bad >= 0) begin errors++; $display("FAIL mid_prefix: got %0d beats first bad %0d expected 5 matching", beats.size(), bad); end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++; if ({io_busy, io_done, io_ram_rd, io_out_valid} !== 4'b0000) begin errors++; $display("FAIL mid_reset_flags: got %b expected 0000", {io_busy, io_done, io_ram_rd, io_out_valid}); end
        checks++; if (io_ram_addr !== 12'h000 || io_out_bits !== 16'h0000) begin errors++; $display("FAIL mid_reset_data: got addr %h bits %h expected 000 0000", io_ram_addr, io_out_bits); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        clear_obs();
        for (int i = 0; i < 8; i++) observe_cycle(MODE_READY);
        checks++; if (doneCycles.size() != 0 || beats.size() != 0) begin errors++; $display("FAIL mid_aborted: got %0d done %0d beats expected 0 0", doneCycles.size(), beats.size()); end
        clear_obs();
        a = 12'($urandom);
        model_cmd(a, 2);
        issue_start(a, 2, MODE_RAND);
        run_until_done(1, 300, MODE_RAND);
        bad = first_diff_beats();
        checks++; if (bad >= 0 || doneCycles.size() != 1) begin errors++; $display("FAIL mid_restart: first bad %0d, %0d done pulses expected -1 and 1", bad, doneCycles.size()); end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        io_start     = 1'b0;
        io_startAddr = 12'h000;
        io_count     = 12'h000;
        io_out_ready = 1'b0;
        for (int i = 0; i < 4096; i++) ramMem[i] = {$urandom, $urandom, $urandom, $urandom};
        test_reset();
        test_single_word();
        test_back_pressure();
        test_wrap();
        test_zero_count();
        test_throughput();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
